s27_array: RTL



---
 rtl/s27_array_if.sv | 30 +++
 rtl/s27_array.sv | 72 +++++++
 2 files changed

// File: rtl/s27_array_if.sv
// s27_array interface: enables, scan pins, per-channel G inputs/outputs
// and the activity counter, with master (driver) and slave (DUT) views.
interface s27_array_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 16
);
  logic             EN;
  logic             SE;
  logic             SI;
  logic             CNT_CLR;
  logic [NCH-1:0]   G0;
  logic [NCH-1:0]   G1;
  logic [NCH-1:0]   G2;
  logic [NCH-1:0]   G3;
  logic [NCH-1:0]   G17;
  logic             SO;
  logic [CNT_W-1:0] ACT_CNT;

  modport master (
    output EN, SE, SI, CNT_CLR,
    output G0, G1, G2, G3,
    input  G17, SO, ACT_CNT
  );

  modport slave (
    input  EN, SE, SI, CNT_CLR,
    input  G0, G1, G2, G3,
    output G17, SO, ACT_CNT
  );
endinterface

// File: rtl/s27_array.sv
// NCH parallel s27 state machines sharing one scan chain,
// with clock enable and a saturating activity counter.
module s27_array #(
  parameter int NCH   = 2,
  parameter int CNT_W = 16
) (
  input  logic     CK,
  input  logic     RSTN,
  s27_array_if.slave io
);

  localparam int CW = 3 * NCH;

  // chain bit 3i = S5, 3i+1 = S6, 3i+2 = S7 of channel i
  logic [CW-1:0]    r_chain;
  logic [CNT_W-1:0] r_cnt;

  logic [NCH-1:0] w_s5, w_s6, w_s7;
  logic [NCH-1:0] w_n8, w_n9, w_n10, w_n11;
  logic [NCH-1:0] w_n12, w_n13, w_n14;
  logic [NCH-1:0] w_n15, w_n16;
  logic [CW-1:0]  w_func;
  logic           w_act;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign w_s5[i] = r_chain[3*i];
    assign w_s6[i] = r_chain[3*i+1];
    assign w_s7[i] = r_chain[3*i+2];
    assign w_func[3*i]   = w_n10[i];
    assign w_func[3*i+1] = w_n11[i];
    assign w_func[3*i+2] = w_n13[i];
  end

  assign w_n14 = ~io.G0;
  assign w_n12 = ~(io.G1 | w_s7);
  assign w_n8  = w_n14 & w_s6;
  assign w_n15 = w_n12 | w_n8;
  assign w_n16 = io.G3 | w_n8;
  assign w_n9  = ~(w_n16 & w_n15);
  assign w_n11 = ~(w_s5 | w_n9);
  assign w_n10 = ~(w_n14 | w_n11);
  assign w_n13 = ~(io.G2 | w_n12);

  assign io.G17     = ~w_n11;
  assign io.SO      = r_chain[CW-1];
  assign io.ACT_CNT = r_cnt;

  assign w_act = !io.SE && io.EN && (|io.G17);

  // state flops: reset, then scan shift, then enabled functional update
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      r_chain <= '0;
    end else if (io.SE) begin
      r_chain <= {r_chain[CW-2:0], io.SI};
    end else if (io.EN) begin
      r_chain <= w_func;
    end
  end

  // activity counter: clear wins, saturates at all-ones
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      r_cnt <= '0;
    end else if (io.CNT_CLR) begin
      r_cnt <= '0;
    end else if (w_act && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule
